// File: rtl/alu_cmd_sequencer_if.sv
// alu_cmd_sequencer_if -- bundles the command, ALU and result signals of
// the sequencer.
//   cmd_*  : upstream command channel (valid/ready, operands A/B, opcode)
//   alu_*  : drive to / return from the combinational ALU
//   res_*  : downstream result channel (valid/ready, data, carry, opcode echo)
// slave  modport: the sequencer itself.
// master modport: the producer/ALU/consumer environment around it.
interface alu_cmd_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_a;
  logic [7:0] cmd_b;
  logic [3:0] cmd_sel;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [3:0] alu_sel;
  logic [7:0] alu_out;
  logic       alu_carry;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic       res_carry;
  logic [3:0] res_sel;

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_sel, alu_out, alu_carry, res_ready,
    output cmd_ready, alu_a, alu_b, alu_sel, res_valid, res_data, res_carry, res_sel
  );

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_sel, alu_out, alu_carry, res_ready,
    input  cmd_ready, alu_a, alu_b, alu_sel, res_valid, res_data, res_carry, res_sel
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer -- command FIFO and registered result slot wrapped
// around an 8-bit combinational ALU.
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   bus      : alu_cmd_sequencer_if.slave (command in, ALU drive/return,
//              result out)
//   stat_ops, stat_carries : capture counters, present only when the macro
//              ALU_SEQ_STATS_EN is defined
// Parameters: DEPTH (power of 2, >= 2), PTR_W = log2(DEPTH).
// The FIFO head drives the ALU combinationally; its result is captured into
// the slot one edge after the command was written, then the head is popped.
module alu_cmd_sequencer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  alu_cmd_sequencer_if.slave    bus
`ifdef ALU_SEQ_STATS_EN
  ,
  output logic [15:0]           stat_ops,
  output logic [15:0]           stat_carries
`endif
);

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] sel;
  } cmd_t;

  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  cmd_t             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  cmd_t             head;
  logic             empty, full, push, cap;

  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);
  assign head  = mem[rd_ptr];

  // Ready is a pure function of the registered count, so a pop in the same
  // cycle never frees a slot for a push while full.
  assign bus.cmd_ready = !full && !rst;
  assign push          = bus.cmd_valid && bus.cmd_ready;
  // The slot takes a new result if it is empty or being drained this edge.
  assign cap           = !empty && (!bus.res_valid || bus.res_ready);

  always_comb begin
    bus.alu_a   = '0;
    bus.alu_b   = '0;
    bus.alu_sel = '0;
    if (!empty) begin
      bus.alu_a   = head.a;
      bus.alu_b   = head.b;
      bus.alu_sel = head.sel;
    end
  end

  // Storage needs no reset: entries are only read while count says valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{a: bus.cmd_a, b: bus.cmd_b, sel: bus.cmd_sel};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (cap)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, cap})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.res_valid <= 1'b0;
      bus.res_data  <= '0;
      bus.res_carry <= 1'b0;
      bus.res_sel   <= '0;
    end else if (cap) begin
      bus.res_valid <= 1'b1;
      bus.res_data  <= bus.alu_out;
      bus.res_carry <= bus.alu_carry;
      bus.res_sel   <= head.sel;
    end else if (bus.res_valid && bus.res_ready) begin
      // Payload keeps its last value after the drain.
      bus.res_valid <= 1'b0;
    end
  end

`ifdef ALU_SEQ_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_ops     <= '0;
      stat_carries <= '0;
    end else if (cap) begin
      stat_ops <= stat_ops + 16'd1;
      if (bus.alu_carry) stat_carries <= stat_carries + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: behavioural ALU on the alu_* pins, directed
// scenarios plus random traffic, scoreboard-checked by a negedge monitor.
module tb_alu_cmd_sequencer;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_cmd_sequencer_if bus();

`ifdef ALU_SEQ_STATS_EN
  logic [15:0] stat_ops, stat_carries;
  alu_cmd_sequencer #(.DEPTH(DEPTH), .PTR_W(2)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave),
    .stat_ops(stat_ops), .stat_carries(stat_carries));
`else
  alu_cmd_sequencer #(.DEPTH(DEPTH), .PTR_W(2)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave));
`endif

  // Reference 8-bit ALU (classic opcode map, carry from A+B).
  function automatic logic [7:0] alu_res(input logic [7:0] a, input logic [7:0] b,
                                         input logic [3:0] sel);
    case (sel)
      4'h0: return a + b;
      4'h1: return a - b;
      4'h2: return a * b;
      4'h3: return (b == 8'd0) ? 8'd0 : a / b;
      4'h4: return a << 1;
      4'h5: return a >> 1;
      4'h6: return {a[6:0], a[7]};
      4'h7: return {a[0], a[7:1]};
      4'h8: return a & b;
      4'h9: return a | b;
      4'hA: return a ^ b;
      4'hB: return ~(a | b);
      4'hC: return ~(a & b);
      4'hD: return ~(a ^ b);
      4'hE: return (a > b) ? 8'd1 : 8'd0;
      default: return (a == b) ? 8'd1 : 8'd0;
    endcase
  endfunction

  function automatic logic alu_cy(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[8];
  endfunction

  assign bus.alu_out   = alu_res(bus.alu_a, bus.alu_b, bus.alu_sel);
  assign bus.alu_carry = alu_cy(bus.alu_a, bus.alu_b);

  typedef struct {logic [7:0] a; logic [7:0] b; logic [3:0] sel;} cmd_s;
  typedef struct {logic [7:0] d; logic c; logic [3:0] s;} res_s;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending commands, result-slot occupancy, expected results.
  cmd_s q[$];
  res_s exp_q[$];
  logic slot_v = 1'b0;
  int   m_ops = 0, m_carries = 0;

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      exp_q.delete();
      slot_v    = 1'b0;
      m_ops     = 0;
      m_carries = 0;
    end else begin
      logic acc, cap_m;
      chk("cmd_ready", 32'(bus.cmd_ready), 32'(q.size() < DEPTH));
      chk("res_valid", 32'(bus.res_valid), 32'(slot_v));
      chk("alu_sel", 32'(bus.alu_sel), (q.size() > 0) ? 32'(q[0].sel) : 32'd0);
      chk("alu_a",   32'(bus.alu_a),   (q.size() > 0) ? 32'(q[0].a)   : 32'd0);
`ifdef ALU_SEQ_STATS_EN
      chk("stat_ops", 32'(stat_ops), 32'(m_ops[15:0]));
      chk("stat_carries", 32'(stat_carries), 32'(m_carries[15:0]));
`endif
      // Result handed over at the coming edge.
      if (slot_v && bus.res_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 32'(bus.res_valid), 32'd0);
        end else begin
          res_s e;
          e = exp_q.pop_front();
          chk("res_data", 32'(bus.res_data), 32'(e.d));
          chk("res_carry", 32'(bus.res_carry), 32'(e.c));
          chk("res_sel", 32'(bus.res_sel), 32'(e.s));
        end
      end
      acc   = bus.cmd_valid && (q.size() < DEPTH);
      cap_m = (q.size() > 0) && (!slot_v || bus.res_ready);
      if (cap_m) begin
        cmd_s h;
        h = q.pop_front();
        m_ops++;
        if (alu_cy(h.a, h.b)) m_carries++;
        slot_v = 1'b1;
      end else if (slot_v && bus.res_ready) begin
        slot_v = 1'b0;
      end
      if (acc) begin
        q.push_back('{a: bus.cmd_a, b: bus.cmd_b, sel: bus.cmd_sel});
        exp_q.push_back('{d: alu_res(bus.cmd_a, bus.cmd_b, bus.cmd_sel),
                          c: alu_cy(bus.cmd_a, bus.cmd_b), s: bus.cmd_sel});
      end
    end
  end

  // Drive one cycle of inputs; entered and left at posedge+1.
  task automatic step(input logic v, input logic [7:0] a, input logic [7:0] b,
                      input logic [3:0] sel, input logic rr);
    bus.cmd_valid = v;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.cmd_sel   = sel;
    bus.res_ready = rr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_a = '0;
    bus.cmd_b = '0;
    bus.cmd_sel = '0;
    bus.res_ready = 1'b0;
    #1;
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset / idle
    step(0, 8'h00, 8'h00, 4'h0, 1);
    step(0, 8'h00, 8'h00, 4'h0, 1);
    chk("idle_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("idle_res_valid", 32'(bus.res_valid), 32'd0);
    chk("idle_res_data", 32'(bus.res_data), 32'd0);
    chk("idle_alu", {12'd0, bus.alu_a, bus.alu_b, bus.alu_sel}, 32'd0);

    // Single op: no bypass, result one edge after acceptance
    step(1, 8'h0A, 8'h02, 4'h0, 1);
    chk("single_no_bypass", 32'(bus.res_valid), 32'd0);
    chk("single_head_a", 32'(bus.alu_a), 32'h0A);
    step(0, 8'h00, 8'h00, 4'h0, 1);
    chk("single_valid", 32'(bus.res_valid), 32'd1);
    chk("single_data", 32'(bus.res_data), 32'h0C);
    chk("single_carry", 32'(bus.res_carry), 32'd0);
    chk("single_sel", 32'(bus.res_sel), 32'h0);

    // Carry case
    step(1, 8'hF6, 8'h0A, 4'h0, 1);
    step(0, 8'h00, 8'h00, 4'h0, 1);
    chk("carry_data", 32'(bus.res_data), 32'h00);
    chk("carry_carry", 32'(bus.res_carry), 32'd1);
    step(0, 8'h00, 8'h00, 4'h0, 1);

    // Back-pressure until full; the 6th command must be refused
    for (int i = 0; i < 5; i++) step(1, 8'h0A, 8'h02, 4'(i), 0);
    chk("full_ready", 32'(bus.cmd_ready), 32'd0);
    step(1, 8'h0A, 8'h02, 4'h5, 0);
    chk("full_count", 32'(dut.count), 32'd4);
    for (int i = 0; i < 5; i++) begin
      chk("drain_sel", 32'(bus.res_sel), 32'(i));
      step(0, 8'h00, 8'h00, 4'h0, 1);
    end
    chk("drain_ready", 32'(bus.cmd_ready), 32'd1);
    chk("drain_empty", 32'(bus.res_valid), 32'd0);

    // Streaming: one result per cycle, occupancy stays at most 1
    for (int i = 0; i < 16; i++) begin
      step(1, 8'h0A, 8'h02, 4'(i), 1);
      chk("stream_count_le1", 32'(dut.count <= 1), 32'd1);
      if (i > 0) chk("stream_sel", 32'(bus.res_sel), 32'(i - 1));
    end
    step(0, 8'h00, 8'h00, 4'h0, 1);
    step(0, 8'h00, 8'h00, 4'h0, 1);

    // Async reset with 3 queued and a pending result
    for (int i = 0; i < 4; i++) step(1, 8'h33, 8'h44, 4'(i + 8), 0);
    chk("pre_rst_count", 32'(dut.count), 32'd3);
    chk("pre_rst_valid", 32'(bus.res_valid), 32'd1);
    bus.cmd_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("async_res_valid", 32'(bus.res_valid), 32'd0);
    chk("async_count", 32'(dut.count), 32'd0);
    chk("async_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    chk("async_res_data", 32'(bus.res_data), 32'd0);
`ifdef ALU_SEQ_STATS_EN
    chk("async_stat_ops", 32'(stat_ops), 32'd0);
    chk("async_stat_carries", 32'(stat_carries), 32'd0);
`endif
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(0, 8'h00, 8'h00, 4'h0, 1);
      chk("no_stale", 32'(bus.res_valid), 32'd0);
    end

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      step(logic'($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom),
           4'($urandom), logic'($urandom_range(0, 3) != 0));
    end
    for (int i = 0; i < 8; i++) step(0, 8'h00, 8'h00, 4'h0, 1);
    chk("final_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Operand/command front end for the 8-bit combinational `alu`.
- Queues operand/opcode commands from an upstream producer in a small FIFO and presents the FIFO head to the ALU's A/B/ALU_Sel inputs.
- Captures ALU_Out/CarryOut into a registered result slot with a valid/ready handshake toward the downstream consumer.
- Sits directly upstream of `alu`, and also registers its output.

Parameters:
- DEPTH, 4, command FIFO depth in entries; power of 2, minimum 2.
- PTR_W, 2, pointer width; must equal log2(DEPTH).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- cmd_valid  input  1  upstream command valid.
- cmd_ready  output  1  sequencer can accept a command.
- cmd_a  input  8  operand A.
- cmd_b  input  8  operand B.
- cmd_sel  input  4  ALU operation select.
- alu_a  output  8  to ALU A.
- alu_b  output  8  to ALU B.
- alu_sel  output  4  to ALU ALU_Sel.
- alu_out  input  8  from ALU ALU_Out.
- alu_carry  input  1  from ALU CarryOut.
- res_valid  output  1  result slot holds a result.
- res_ready  input  1  downstream accepts the result.
- res_data  output  8  captured ALU_Out.
- res_carry  output  1  captured CarryOut.
- res_sel  output  4  opcode echo for the captured result.

Behaviour:
- Reset (async, rst=1): FIFO empty, pointers=0, count=0.
  - Outputs: res_valid=0, res_data=0, res_carry=0, res_sel=0.
  - cmd_ready=1 once rst deasserts (0 while rst=1).
  - Reset mid-operation discards all queued commands and any pending result; nothing is replayed.
- Push: cmd_valid && cmd_ready at a rising edge writes {cmd_a, cmd_b, cmd_sel} at the write pointer.
  - cmd_ready = !full && !rst, purely from registered count.
  - No push while full, even if a pop occurs the same cycle; there is no pass-through.
- ALU drive (combinational from FIFO head):
  - Non-empty: alu_a/alu_b/alu_sel = head entry.
  - Empty: alu_a/alu_b/alu_sel = 0.
- Capture condition: `cap = !empty && (!res_valid || res_ready)`.
  - On cap: res_data<=alu_out, res_carry<=alu_carry, res_sel<=head sel, res_valid<=1; head is popped.
- Drain: res_valid && res_ready && !cap → res_valid<=0. res_data/res_carry/res_sel hold their last values.
- Latency: command accepted at edge k is captured at edge k+1, so res_valid is high after edge k+1 if the slot is free. There is no same-cycle bypass.
- Throughput: 1 result/cycle sustained while res_ready=1 and the FIFO is non-empty.
- Stall: res_ready=0 with res_valid=1 freezes the result slot and the head. The FIFO keeps filling until count==DEPTH, then cmd_ready=0.
- Simultaneous push+pop (non-full): count unchanged, both pointers advance.
- Pointers: PTR_W bits, wrap modulo DEPTH. count is PTR_W+1 bits, range 0..DEPTH.
- Width rules: the sequencer does no arithmetic on data. Results and carry are taken verbatim from the ALU.

Optional Feature:
- Macro: ALU_SEQ_STATS_EN.
- Defined:
  - Adds outputs stat_ops[15:0] and stat_carries[15:0], reset to 0.
  - stat_ops increments on each cap.
  - stat_carries increments on each cap with alu_carry=1.
  - Both counters wrap 0xFFFF→0x0000.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

Test Plan (sequencer wired to a real `alu` instance):
- Reset/idle: pulse rst, then hold cmd_valid=0 → cmd_ready=1, res_valid=0, res_data=0x00, alu_a/alu_b/alu_sel=0.
- Single op: push A=0x0A, B=0x02, sel=0x0 (add) with res_ready=1 → res_valid=1 one cycle after acceptance, res_data=0x0C, res_carry=0, res_sel=0x0.
- Carry case: push A=0xF6, B=0x0A, sel=0x0 → res_data=0x00, res_carry=1.
- Back-pressure/full: res_ready=0, push 6 commands (A=0x0A, B=0x02, sel=0x0..0x5).
  - Required: first result captured, then 4 queued, and cmd_ready=0 on the 6th attempt.
  - Then raise res_ready → 5 results emerge on consecutive cycles with res_sel 0..4, in order.
  - After that, cmd_ready returns to 1.
- Streaming: push sel=0x0..0xF back-to-back with res_ready=1 → 16 results, one per cycle, in order.
  - res_data must match the ALU golden model for A=0x0A, B=0x02.
  - count must never exceed 1.
- Async reset mid-stream: assert rst between clock edges with 3 entries queued and res_valid=1.
  - Required: res_valid and count clear immediately without waiting for a clock edge.
  - After release, no stale result appears.
  - With ALU_SEQ_STATS_EN defined, the stat counters read 0.
